// File: rtl/gng_pkg.sv
// gng_pkg: shared widths, rounding constant and torus word type for the noise path
package gng_pkg;
  localparam int TORUS_W = 32;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_FRAC = 11;
  localparam int ROUND_HALF = 1 << (SAMPLE_FRAC - 1);
  typedef logic [TORUS_W-1:0] torus_t;
endpackage

// File: rtl/gng_torus_noise_if.sv
// gng_torus_noise_if: valid/ready stream carrying Torus32 noise words
interface gng_torus_noise_if;
  import gng_pkg::*;
  logic noise_valid;
  logic noise_ready;
  torus_t noise_data;
  modport master(output noise_valid, output noise_data, input noise_ready);
  modport slave(input noise_valid, input noise_data, output noise_ready);
endinterface

// File: rtl/gng_noise_fifo.sv
// gng_noise_fifo: show-ahead synchronous FIFO with registered head word and occupancy
module gng_noise_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_rd,
  output logic                     o_valid,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [W-1:0] r_data, w_next;
  logic [AW-1:0] w_rn;
  logic w_rd, w_wr;
  assign o_level = r_wptr - r_rptr;
  assign o_valid = o_level != '0;
  assign o_data = r_data;
  assign w_rd = i_rd & o_valid;
  assign w_wr = i_wr & ((o_level != (AW+1)'(DEPTH)) | w_rd);
  assign w_rn = r_rptr[AW-1:0] + AW'(1);
  // Next head word: the following entry on a pop, the incoming word when it becomes the head, else hold
  always_comb
    w_next = (w_rd && o_level > (AW+1)'(1)) ? r_mem[w_rn] :
             (w_wr && (o_level == '0 || (w_rd && o_level == (AW+1)'(1)))) ? i_wdata : r_data;
  // Storage array, written at the write pointer; contents need no reset
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  // Pointers with an extra wrap bit and the registered head word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_data <= '0;
    end else begin
      r_wptr <= r_wptr + (AW+1)'(w_wr);
      r_rptr <= r_rptr + (AW+1)'(w_rd);
      r_data <= w_next;
    end
endmodule

// File: rtl/gng_torus_noise.sv
// gng_torus_noise: scales Gaussian samples to Torus32 error terms and buffers them with throttled generation
module gng_torus_noise
  import gng_pkg::*;
#(
  parameter logic [31:0] SIGMA_Q32 = 32'h0001_0000,
  parameter int DEPTH = 16,
  parameter int SKID = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  output logic                    o_gng_ce,
  input  logic                    i_gng_valid,
  input  logic [31:0]             i_gng_data,
  gng_torus_noise_if.master       noise,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow
);
  localparam int PW = SAMPLE_W + TORUS_W + 1;
  localparam int LW = $clog2(DEPTH) + 1;
  logic signed [PW-1:0] r_p;
  torus_t r_word;
  logic r_v1, r_v2, r_ce, r_ovf;
  logic w_rd, w_full, w_ce, w_unused;
  assign w_unused = ^i_gng_data[31:SAMPLE_W];
  assign w_rd = noise.noise_valid & noise.noise_ready;
  assign w_full = o_level == LW'(DEPTH);
  assign w_ce = i_enable && (32'(o_level) + 32'(r_v1) + 32'(r_v2) + 32'(SKID) < 32'(DEPTH));
  assign o_gng_ce = r_ce;
  assign o_overflow = r_ovf;
  // Two-stage scaler: multiply by sigma, then round half-up and keep the low 32 bits as the torus wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_p <= '0;
      r_word <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_p <= $signed(i_gng_data[SAMPLE_W-1:0]) * $signed({1'b0, SIGMA_Q32});
      r_v1 <= i_gng_valid;
      r_word <= TORUS_W'((r_p + PW'(ROUND_HALF)) >>> SAMPLE_FRAC);
      r_v2 <= r_v1;
    end
  // Generator clock enable keeps a reserve of free slots for samples already in flight; overflow is sticky
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ce <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_ce <= w_ce;
      r_ovf <= r_ovf | (r_v2 & w_full & ~w_rd);
    end
  gng_noise_fifo #(.DEPTH(DEPTH), .W(TORUS_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr(r_v2),
    .i_wdata(r_word),
    .i_rd(noise.noise_ready),
    .o_valid(noise.noise_valid),
    .o_data(noise.noise_data),
    .o_level(o_level)
  );
endmodule

// File: tb/tb_gng_torus_noise.sv
// tb_gng_torus_noise: randomized and directed checks of the torus noise buffer against a reference model
module tb_gng_torus_noise;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_en = 1'b0, a_gv = 1'b0, a_ce, a_ovf;
  logic b_en = 1'b0, b_gv = 1'b0, b_ce, b_ovf;
  logic [31:0] a_gd = '0, b_gd = '0;
  logic [4:0] a_lvl, b_lvl;
  logic [31:0] qa[$], qb[$];
  int n_chk = 0, n_pass = 0;
  gng_torus_noise_if nif_a();
  gng_torus_noise_if nif_b();
  gng_torus_noise dut_a (.clk(clk), .rst(rst), .i_enable(a_en), .o_gng_ce(a_ce), .i_gng_valid(a_gv),
    .i_gng_data(a_gd), .noise(nif_a), .o_level(a_lvl), .o_overflow(a_ovf));
  gng_torus_noise #(.SIGMA_Q32(32'h0000_0400), .DEPTH(16), .SKID(0)) dut_b (.clk(clk), .rst(rst),
    .i_enable(b_en), .o_gng_ce(b_ce), .i_gng_valid(b_gv), .i_gng_data(b_gd), .noise(nif_b),
    .o_level(b_lvl), .o_overflow(b_ovf));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] ref_noise(input logic [15:0] x, input longint sigma);
    longint v = longint'($signed(x)) * sigma;
    return 32'((v + 1024) >>> 11);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input bit sel, input logic [15:0] x, input logic [31:0] exp, input string tag);
    if (sel) begin b_gv = 1'b1; b_gd = {16'hDEAD, x}; end
    else begin a_gv = 1'b1; a_gd = {16'hBEEF, x}; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_lat"}, sel ? nif_b.noise_valid : nif_a.noise_valid, 0);
      tick();
      a_gv = 1'b0;
      b_gv = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_vld"}, sel ? nif_b.noise_valid : nif_a.noise_valid, 1);
    chk(tag, sel ? nif_b.noise_data : nif_a.noise_data, exp);
    tick();
  endtask

  task automatic drain(input bit sel, input int cycles, input string tag);
    logic [31:0] e;
    int sz;
    if (sel) nif_b.noise_ready = 1'b1; else nif_a.noise_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sel ? nif_b.noise_valid : nif_a.noise_valid) begin
        sz = sel ? qb.size() : qa.size();
        chk({tag, "_q"}, sz != 0, 1);
        if (sz != 0) begin
          e = sel ? qb.pop_front() : qa.pop_front();
          chk(tag, sel ? nif_b.noise_data : nif_a.noise_data, e);
        end
      end
      tick();
    end
    chk({tag, "_empty"}, sel ? qb.size() : qa.size(), 0);
    chk({tag, "_idle"}, sel ? nif_b.noise_valid : nif_a.noise_valid, 0);
  endtask

  initial begin
    int peak;
    nif_a.noise_ready = 1'b0;
    nif_b.noise_ready = 1'b0;
    #1;
    @(negedge clk);
    chk("rst_vld", nif_a.noise_valid, 0);
    chk("rst_data", nif_a.noise_data, 0);
    chk("rst_lvl", a_lvl, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_ce", a_ce, 0);
    tick();
    rst = 1'b0;
    tick();
    nif_a.noise_ready = 1'b1;
    nif_b.noise_ready = 1'b1;
    send_dir(0, 16'h0800, 32'h0001_0000, "pos_one");
    send_dir(0, 16'hF800, 32'hFFFF_0000, "neg_one");
    send_dir(0, 16'h0000, 32'h0000_0000, "zero");
    send_dir(1, 16'h0001, 32'h0000_0001, "rnd_up");
    send_dir(1, 16'hFFFF, 32'h0000_0000, "rnd_half");
    // Random stream: generator honours gng_ce, consumer randomly stalls
    a_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      a_gv = a_ce & 1'($urandom_range(0, 1));
      a_gd = $urandom;
      if (a_gv) qa.push_back(ref_noise(a_gd[15:0], 64'h1_0000));
      nif_a.noise_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (nif_a.noise_valid && nif_a.noise_ready) begin
        chk("stream_q", qa.size() != 0, 1);
        if (qa.size() != 0) chk("stream", nif_a.noise_data, qa.pop_front());
      end
    end
    tick();
    a_gv = 1'b0;
    a_en = 1'b0;
    chk("stream_ovf", a_ovf, 0);
    drain(0, 30, "stream_drain");
    // Backpressure: consumer stalled, generator stops once the reserve is reached
    nif_a.noise_ready = 1'b0;
    a_en = 1'b1;
    peak = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      a_gv = a_ce;
      a_gd = $urandom;
      if (a_gv) qa.push_back(ref_noise(a_gd[15:0], 64'h1_0000));
      @(negedge clk);
      if (int'(a_lvl) > peak) peak = int'(a_lvl);
    end
    tick();
    a_gv = 1'b0;
    @(negedge clk);
    chk("bp_ce", a_ce, 0);
    chk("bp_peak", peak <= 16, 1);
    chk("bp_reserve", a_lvl >= 5'd8, 1);
    chk("bp_lvl", a_lvl, qa.size());
    chk("bp_ovf", a_ovf, 0);
    tick();
    a_en = 1'b0;
    drain(0, 30, "bp_drain");
    // Overflow: no reserve, samples forced in while the consumer is stalled
    nif_b.noise_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b_gv = 1'b1;
      b_gd = $urandom;
      if (i < 16) qb.push_back(ref_noise(b_gd[15:0], 64'h400));
      tick();
    end
    b_gv = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("ovf_flag", b_ovf, 1);
    chk("ovf_lvl", b_lvl, 16);
    tick();
    drain(1, 24, "ovf_drain");
    chk("ovf_sticky", b_ovf, 1);
    // Reset mid-operation with queued and in-flight words
    nif_a.noise_ready = 1'b0;
    a_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_gv = 1'b1;
      a_gd = $urandom;
      tick();
    end
    a_gv = 1'b0;
    chk("pre_rst_lvl", a_lvl, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", nif_a.noise_valid, 0);
    chk("mid_rst_lvl", a_lvl, 0);
    chk("mid_rst_ovf", b_ovf, 0);
    chk("mid_rst_ce", a_ce, 0);
    tick();
    rst = 1'b0;
    a_en = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_vld", nif_a.noise_valid, 0);
      tick();
    end
    chk("post_rst_lvl", a_lvl, 0);
    nif_a.noise_ready = 1'b1;
    send_dir(0, 16'h0400, ref_noise(16'h0400, 64'h1_0000), "post_rst_first");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
